// File: rtl/alu_seq_pkg.sv
// Shared opcode map, status flag positions and FSM encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_CPL  = 4'b0111;
    localparam logic [3:0] OP_NEG  = 4'b1000;
    localparam logic [3:0] OP_ASL  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_LSL  = 4'b1011;
    localparam logic [3:0] OP_LSR  = 4'b1100;
    localparam logic [3:0] OP_ROL  = 4'b1101;
    localparam logic [3:0] OP_ROR  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    localparam int F_P = 4;
    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_S = 1;
    localparam int F_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per clock.
module alu_seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] step_next;

    // Upper half accumulates; lower half holds the remaining multiplier bits.
    always_comb begin
        partial   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                  + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        step_next = {partial, prod_reg[WIDTH-1:1]};
    end

    // product is the value after this cycle's step, so it is final while done is high.
    assign product = step_next;
    assign done    = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            prod_reg  <= '0;
            cnt_reg   <= '0;
        end else if (start) begin
            mcand_reg <= a;
            prod_reg  <= {{WIDTH{1'b0}}, b};
            cnt_reg   <= CNT_W'(WIDTH);
        end else if (cnt_reg != '0) begin
            prod_reg  <= step_next;
            cnt_reg   <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and a multi-cycle multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [3:0]       opCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       status
);

    state_t             state_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [4:0]         status_reg;
    logic               out_valid_reg;
    logic               in_ready_reg;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_c;
    logic               alu_o;
    logic [4:0]         alu_status;
    logic [4:0]         mul_status;
    logic               mul_start;
    logic               mul_done;
    logic               mul_hi;
    logic [2*WIDTH-1:0] mul_product;

    function automatic logic [4:0] make_status(input logic [WIDTH-1:0] res,
                                               input logic c, input logic o);
        logic [4:0] s;
        s      = '0;
        s[F_P] = ^res;
        s[F_Z] = (res == '0);
        s[F_C] = c;
        s[F_S] = res[WIDTH-1];
        s[F_O] = o;
        return s;
    endfunction

    always_comb begin
        sum_ext    = {1'b0, iA} + {1'b0, iB};
        diff_ext   = {1'b0, iA} - {1'b0, iB};
        alu_result = '0;
        alu_c      = 1'b0;
        alu_o      = 1'b0;
        case (opCode)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_c      = sum_ext[WIDTH];
                alu_o      = (iA[WIDTH-1] == iB[WIDTH-1]) && (sum_ext[WIDTH-1] != iA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff_ext[WIDTH-1:0];
                alu_c      = diff_ext[WIDTH];
                alu_o      = (iA[WIDTH-1] != iB[WIDTH-1]) && (diff_ext[WIDTH-1] != iA[WIDTH-1]);
            end
            OP_AND: alu_result = iA & iB;
            OP_OR:  alu_result = iA | iB;
            OP_NOT: alu_result = ~iA;
            OP_XOR: alu_result = iA ^ iB;
            OP_CPL: alu_result = ~iA;
            OP_NEG: begin
                alu_result = -iA;
                alu_o      = (iA == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_ASL: begin
                alu_result = {iA[WIDTH-2:0], 1'b0};
                alu_c      = iA[WIDTH-1];
                alu_o      = iA[WIDTH-2] != iA[WIDTH-1];
            end
            OP_ASR: begin
                alu_result = {iA[WIDTH-1], iA[WIDTH-1:1]};
                alu_c      = iA[0];
            end
            OP_LSL: begin
                alu_result = {iA[WIDTH-2:0], 1'b0};
                alu_c      = iA[WIDTH-1];
            end
            OP_LSR: begin
                alu_result = {1'b0, iA[WIDTH-1:1]};
                alu_c      = iA[0];
            end
            OP_ROL: begin
                alu_result = {iA[WIDTH-2:0], iA[WIDTH-1]};
                alu_c      = iA[WIDTH-1];
            end
            OP_ROR: begin
                alu_result = {iA[0], iA[WIDTH-1:1]};
                alu_c      = iA[0];
            end
            default: alu_result = '0;
        endcase
        alu_status = make_status(alu_result, alu_c, alu_o);
        mul_hi     = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_status = make_status(mul_product[WIDTH-1:0], mul_hi, mul_hi);
    end

    assign mul_start = (state_reg == ST_IDLE) && in_valid && (opCode == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (iA),
        .b       (iB),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            status_reg    <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (opCode == OP_MUL) begin
                            state_reg <= ST_MUL;
                        end else begin
                            result_reg    <= alu_result;
                            status_reg    <= alu_status;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_reg    <= mul_product[WIDTH-1:0];
                        status_reg    <= mul_status;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign result    = result_reg;
    assign status    = status_reg;
    assign out_valid = out_valid_reg;
    assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expected results.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic [3:0]       opCode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       status;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .iA        (iA),
        .iB        (iB),
        .opCode    (opCode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-18s observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        opCode   = op;
        iA       = a;
        iB       = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen; capped at 50.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic [4:0] exp_stat, input int exp_lat);
        int n;
        start_op(op, a, b);
        wait_out(n);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, 32'(result), 32'(exp_res));
        chk({tag, "_stat"}, 32'(status), 32'(exp_stat));
        @(posedge clk); #1;
        chk({tag, "_retire"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        iA        = '0;
        iB        = '0;
        opCode    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Reset while a multiply is in flight.
        start_op(OP_MUL, 8'hFF, 8'hFF);
        chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_1_1", OP_ADD, 8'h01, 8'h01, 8'h02, 5'b10000, 0);

        run_op("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b10011, 0);
        run_op("sub_zero", OP_SUB, 8'h05, 8'h05, 8'h00, 5'b01000, 0);
        run_op("sub_borrow", OP_SUB, 8'h03, 8'h05, 8'hFE, 5'b10110, 0);
        run_op("mul_hi", OP_MUL, 8'h10, 8'h20, 8'h00, 5'b01101, 8);
        run_op("mul_0f", OP_MUL, 8'h0F, 8'h0F, 8'hE1, 5'b00010, 8);
        run_op("mul_ff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 5'b10101, 8);
        run_op("asr_81", OP_ASR, 8'h81, 8'h00, 8'hC0, 5'b00110, 0);
        run_op("rol_81", OP_ROL, 8'h81, 8'h00, 8'h03, 5'b00100, 0);
        run_op("neg_80", OP_NEG, 8'h80, 8'h00, 8'h80, 5'b10011, 0);
        run_op("neg_01", OP_NEG, 8'h01, 8'h00, 8'hFF, 5'b00010, 0);
        run_op("ror_01", OP_ROR, 8'h01, 8'h00, 8'h80, 5'b10110, 0);
        run_op("lsr_01", OP_LSR, 8'h01, 8'h00, 8'h00, 5'b01100, 0);
        run_op("asl_40", OP_ASL, 8'h40, 8'h00, 8'h80, 5'b10011, 0);
        run_op("nop", OP_NOP, 8'h5A, 8'hA5, 8'h00, 5'b01000, 0);

        // Back-pressure: result held and new requests ignored while out_ready=0.
        out_ready = 1'b0;
        start_op(OP_XOR, 8'h0F, 8'h3C);
        wait_out(lat);
        chk("bp_lat", 32'(lat), 32'd0);
        chk("bp_res", 32'(result), 32'h33);
        chk("bp_stat", 32'(status), 32'b00000);
        opCode   = OP_ADD;
        iA       = 8'h11;
        iB       = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_res", 32'(result), 32'h33);
            chk("bp_hold_stat", 32'(status), 32'b00000);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        run_op("post_bp_or", OP_OR, 8'h50, 8'h05, 8'h55, 5'b00000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit ALU. Operand width is set by WIDTH, and the opcode map is unchanged.
- Adds a valid/ready handshake on input and output, plus a multi-cycle shift-add multiply (opcode 4'b1111).
- Keeps the 5-bit [P,Z,C,S,O] status flag layout.
- Sits between the control unit's operand registers and the register-file writeback stage.

Parameters:
- WIDTH, 8: operand and result width, range 4 to 32.
- CNT_W, $clog2(WIDTH)+1: width of the multiply iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept a new operation.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- opCode  in  4  operation select.
- out_valid  out  1  result and status are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- status  out  5  flags {P,Z,C,S,O} at bits [4:0].

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE; result=0, status=0, out_valid=0, in_ready=1.
  - Any in-flight multiply is discarded.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, the operands and opcode are captured.
    - opCode=1111: go to MUL, load counter=WIDTH.
    - Any other opcode: compute the result and flags combinationally from the inputs, register them, go to DONE. Latency is 1 cycle.
  - MUL: one shift-add step per cycle. Counter decrements each cycle; at counter=1 the next state is DONE. out_valid rises WIDTH cycles after the accept edge. in_ready=0.
  - DONE: out_valid=1; result and status are held stable. When out_ready=1, go to IDLE.
- in_ready is 1 only in IDLE. There is no overlap of operations, and a new accept cannot occur in the same cycle as the out handshake.
- out_valid stays high until out_ready. Values must not change while out_valid=1 and out_ready=0.
- Opcode map:
  - 0001 add; 0010 sub.
  - 0011 and; 0100 or; 0101 not A; 0110 xor; 0111 one's complement A; 1000 two's complement A.
  - 1001 arithmetic shift left; 1010 arithmetic shift right (sign kept).
  - 1011 logical shift left; 1100 logical shift right.
  - 1101 rotate left; 1110 rotate right; 1111 unsigned multiply (low WIDTH bits).
  - 0000: result=0, flags computed normally (Z=1).
- Flags, computed from the final WIDTH-bit result:
  - P = XOR of all result bits (1 = odd parity).
  - Z = result is zero.
  - S = result[WIDTH-1].
  - C depends on the opcode:
    - add: carry out.
    - sub: borrow, i.e. A<B unsigned.
    - shifts: the bit shifted out.
    - rotates: the bit that wrapped.
    - mul: upper half of the 2·WIDTH product is nonzero.
    - all other opcodes: 0.
  - O depends on the opcode:
    - add: signed overflow (operands same sign, result sign differs).
    - sub: operands differ in sign and result sign differs from A.
    - 1000: A = 100..0.
    - 1001: result[WIDTH-1] != A[WIDTH-1].
    - mul: same as C.
    - all other opcodes: 0.
- Every combinational path assigns defaults first, so no latches are inferred.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD … OP_MUL);
  - flag index localparams (F_P=4, F_Z=3, F_C=2, F_S=1, F_O=0);
  - FSM state encoding.
- Sub-module alu_seq_mul: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, 2·WIDTH product.
  - Instantiated once, driven by the MUL state.

Test Plan:
1. Reset mid-multiply: WIDTH=8, start 1111 A=0xFF B=0xFF, assert rst_n=0 at cycle 3 → result=0, status=0, out_valid=0, in_ready=1 immediately; next op 0001 A=1 B=1 → result=0x02 after 1 cycle.
2. Add overflow: 0001 A=0x7F B=0x01 → result=0x80, status P=1, Z=0, C=0, S=1, O=1 (5'b10011), out_valid 1 cycle after accept.
3. Sub borrow and zero:
   - 0010 A=0x05 B=0x05 → result=0x00, status=5'b01000.
   - 0010 A=0x03 B=0x05 → result=0xFE, C=1, S=1.
4. Multiply latency: 1111 A=0x10 B=0x20 → out_valid exactly 8 cycles after accept, result=0x00, C=1, O=1, Z=1.
5. Back-pressure: any op with out_ready=0 for 5 cycles → result/status stable, in_ready=0, in_valid ignored; out_ready=1 → IDLE next cycle.
6. Shifts/rotates:
   - 1010 A=0x81 → 0xC0, C=1.
   - 1101 A=0x81 → 0x03, C=1.
   - 1000 A=0x80 → 0x80, O=1.
